// File: rtl/csp_channel.sv
// csp_channel: single-slot four-phase bundled-data channel with independent sender/receiver FSMs.
// Optional CSP peek/probe outputs are enabled by defining CSP_CHANNEL_PEEK_EN.
module csp_channel #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             full
`ifdef CSP_CHANNEL_PEEK_EN
  ,
  output logic             peek_valid,
  output logic [WIDTH-1:0] peek_data
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} snd_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2} rcv_state_t;

  snd_state_t       r_snd_state;
  snd_state_t       w_snd_nxt;
  rcv_state_t       r_rcv_state;
  rcv_state_t       w_rcv_nxt;
  logic             r_full;
  logic             r_sack;
  logic             r_rreq;
  logic [WIDTH-1:0] r_hold;
  logic             w_release;
  logic             w_load;
  logic             w_full_nxt;

  // Next-state logic; a release in the same edge lets the sender reload the slot directly.
  always_comb begin
    w_release  = (r_rcv_state == R_REQ) && r_ack;
    w_load     = (r_snd_state == S_IDLE) && s_req && (!r_full || w_release);
    w_snd_nxt  = r_snd_state;
    w_rcv_nxt  = r_rcv_state;
    w_full_nxt = r_full;

    case (r_snd_state)
      S_IDLE:  if (w_load) w_snd_nxt = S_ACK; else w_snd_nxt = S_IDLE;
      S_ACK:   if (!s_req) w_snd_nxt = S_IDLE; else w_snd_nxt = S_ACK;
      default: w_snd_nxt = S_IDLE;
    endcase

    case (r_rcv_state)
      R_IDLE:  if (r_full) w_rcv_nxt = R_REQ; else w_rcv_nxt = R_IDLE;
      R_REQ:   if (r_ack) w_rcv_nxt = R_WAIT; else w_rcv_nxt = R_REQ;
      R_WAIT:  if (!r_ack) w_rcv_nxt = R_IDLE; else w_rcv_nxt = R_WAIT;
      default: w_rcv_nxt = R_IDLE;
    endcase

    if (w_load) begin
      w_full_nxt = 1'b1;
    end else if (w_release) begin
      w_full_nxt = 1'b0;
    end else begin
      w_full_nxt = r_full;
    end
  end

  // State, handshake outputs and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snd_state <= S_IDLE;
      r_rcv_state <= R_IDLE;
      r_full      <= 1'b0;
      r_sack      <= 1'b0;
      r_rreq      <= 1'b0;
      r_hold      <= {WIDTH{1'b0}};
    end else begin
      r_snd_state <= w_snd_nxt;
      r_rcv_state <= w_rcv_nxt;
      r_full      <= w_full_nxt;
      r_sack      <= (w_snd_nxt == S_ACK);
      r_rreq      <= (w_rcv_nxt == R_REQ);
      if (w_load) begin
        r_hold <= s_data;
      end else begin
        r_hold <= r_hold;
      end
    end
  end

  assign s_ack  = r_sack;
  assign r_req  = r_rreq;
  assign r_data = r_hold;
  assign full   = r_full;

`ifdef CSP_CHANNEL_PEEK_EN
  assign peek_valid = r_full;
  assign peek_data  = r_hold;
`endif

endmodule

// File: tb/tb_csp_channel.sv
// Directed self-checking bench for csp_channel; peek checks compile in with CSP_CHANNEL_PEEK_EN.
module tb_csp_channel;

  localparam int W = 35;

  logic         clk;
  logic         rst;
  logic         s_req;
  logic [W-1:0] s_data;
  logic         s_ack;
  logic         r_req;
  logic [W-1:0] r_data;
  logic         r_ack;
  logic         full;
`ifdef CSP_CHANNEL_PEEK_EN
  logic         peek_valid;
  logic [W-1:0] peek_data;
`endif

  int checks;
  int errors;

  csp_channel #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_req  (s_req),
    .s_data (s_data),
    .s_ack  (s_ack),
    .r_req  (r_req),
    .r_data (r_data),
    .r_ack  (r_ack),
    .full   (full)
`ifdef CSP_CHANNEL_PEEK_EN
    ,
    .peek_valid (peek_valid),
    .peek_data  (peek_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] rx [10];
  int           rise [10];
  int           rx_cnt;
  int           tx_idx;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    s_req  = 1'b0;
    s_data = '0;
    r_ack  = 1'b0;

    // Reset state
    tick();
    tick();
    check1("rst_s_ack", s_ack, 1'b0);
    check1("rst_r_req", r_req, 1'b0);
    check1("rst_full", full, 1'b0);
    checkw("rst_r_data", r_data, 35'h0);
`ifdef CSP_CHANNEL_PEEK_EN
    check1("rst_peek_valid", peek_valid, 1'b0);
    checkw("rst_peek_data", peek_data, 35'h0);
`endif
    rst = 1'b0;
    tick();

    // Single transfer
    s_data = 35'h3_8000_0025;
    s_req  = 1'b1;
    tick();
    check1("single_s_ack", s_ack, 1'b1);
    check1("single_full", full, 1'b1);
    check1("single_r_req_early", r_req, 1'b0);
    s_req = 1'b0;
    tick();
    check1("single_r_req", r_req, 1'b1);
    checkw("single_r_data", r_data, 35'h3_8000_0025);
    check1("single_s_ack_drop", s_ack, 1'b0);
    r_ack = 1'b1;
    tick();
    check1("single_r_req_drop", r_req, 1'b0);
    check1("single_full_clear", full, 1'b0);
    r_ack = 1'b0;
    tick();
    check1("single_idle_r_req", r_req, 1'b0);

    // Backpressure
    s_data = 35'h1_0000_0001;
    s_req  = 1'b1;
    tick();
    check1("bp_first_s_ack", s_ack, 1'b1);
    s_req = 1'b0;
    tick();
    check1("bp_first_r_req", r_req, 1'b1);
    s_data = 35'h2_0000_0002;
    s_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("bp_second_s_ack_held", s_ack, 1'b0);
      checkw("bp_r_data_held", r_data, 35'h1_0000_0001);
      check1("bp_r_req_held", r_req, 1'b1);
    end
    r_ack = 1'b1;
    tick();
    check1("bp_second_s_ack", s_ack, 1'b1);
    checkw("bp_second_loaded", r_data, 35'h2_0000_0002);
    check1("bp_r_req_low", r_req, 1'b0);
    check1("bp_full_kept", full, 1'b1);
    s_req = 1'b0;
    tick();
    check1("bp_r_req_wait1", r_req, 1'b0);
    tick();
    check1("bp_r_req_wait2", r_req, 1'b0);
    r_ack = 1'b0;
    tick();
    check1("bp_r_req_idle", r_req, 1'b0);
    tick();
    check1("bp_r_req_rerise", r_req, 1'b1);
    checkw("bp_r_data_second", r_data, 35'h2_0000_0002);
    r_ack = 1'b1;
    tick();
    check1("bp_full_clear", full, 1'b0);
    r_ack = 1'b0;
    tick();

    // Stream of 10 tokens with zero-turnaround agents
    rx_cnt = 0;
    tx_idx = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (s_req && s_ack) begin
        s_req  = 1'b0;
        tx_idx = tx_idx + 1;
      end else if (!s_req && !s_ack && tx_idx < 10) begin
        s_req  = 1'b1;
        s_data = 35'(tx_idx);
      end
      if (r_req && !r_ack) begin
        if (rx_cnt < 10) begin
          rx[rx_cnt]   = r_data;
          rise[rx_cnt] = cyc;
        end
        rx_cnt = rx_cnt + 1;
        r_ack  = 1'b1;
      end else if (!r_req && r_ack) begin
        r_ack = 1'b0;
      end
      tick();
    end
    check1("stream_count", (rx_cnt == 10), 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkw("stream_order", rx[i], 35'(i));
    end
    check1("stream_interval_mid", ((rise[5] - rise[4]) >= 3) && ((rise[5] - rise[4]) <= 4), 1'b1);
    check1("stream_interval_end", ((rise[9] - rise[8]) >= 3) && ((rise[9] - rise[8]) <= 4), 1'b1);
    check1("stream_drained", full, 1'b0);
    s_req = 1'b0;
    r_ack = 1'b0;
    tick();

    // Reset mid-transfer
    s_data = 35'h0_0000_00FF;
    s_req  = 1'b1;
    tick();
    tick();
    check1("midrst_r_req_pre", r_req, 1'b1);
    check1("midrst_s_ack_pre", s_ack, 1'b1);
    checkw("midrst_r_data_pre", r_data, 35'h0_0000_00FF);
    rst = 1'b1;
    #1;
    check1("midrst_r_req", r_req, 1'b0);
    check1("midrst_s_ack", s_ack, 1'b0);
    check1("midrst_full", full, 1'b0);
    s_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Spurious r_ack in R_IDLE with empty slot
    r_ack = 1'b1;
    tick();
    tick();
    check1("spur_r_req", r_req, 1'b0);
    check1("spur_full", full, 1'b0);
    check1("spur_s_ack", s_ack, 1'b0);
    r_ack = 1'b0;
    tick();
    check1("spur_r_req_after", r_req, 1'b0);

`ifdef CSP_CHANNEL_PEEK_EN
    // Peek without consuming
    s_data = 35'h4_0000_0013;
    s_req  = 1'b1;
    tick();
    check1("peek_valid_set", peek_valid, 1'b1);
    checkw("peek_data", peek_data, 35'h4_0000_0013);
    s_req = 1'b0;
    tick();
    check1("peek_valid_held", peek_valid, 1'b1);
    r_ack = 1'b1;
    tick();
    r_ack = 1'b0;
    tick();
    check1("peek_valid_clear", peek_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
